pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_perf_cnt.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the mul/div FSM state encoding, the default mul/div occupancy and the MD counter width.
// Optional feature macro used by this block: HAZARD_PERF_CNT_EN (stall-cycle performance counter).
package hazard_pkg;

  // Default number of cycles a mul/div op occupies EX (legal range 2..15).
  localparam int MD_CYCLES_DEFAULT = 4;

  // Width of the mul/div down-counter; 4 bits covers the full 2..15 range.
  localparam int MD_CNT_W = 4;

  typedef logic [MD_CNT_W-1:0] md_cnt_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Counter load value on mul/div accept: the accept cycle is the first EX cycle,
  // so the busy phase counts down the remaining cycles - 1 .. 1.
  function automatic md_cnt_t md_cnt_load(input int cycles);
    return md_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Purpose: 16-bit saturating stall-cycle counter with synchronous clear.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; counts every enabled cycle, holds at 16'hFFFF.
// Feature macro: HAZARD_PERF_CNT_EN. Without it the count is a constant 0 and no flops exist.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] count
);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] cnt_q;

  // Count enabled cycles, stopping at all-ones so the value never wraps.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign count = cnt_q;
`else
  // Counter compiled out: inputs are intentionally left unused.
  logic unused_perf_inputs;
  assign unused_perf_inputs = ^{clk, clear, enable};
  assign count = 16'd0;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: 5-stage pipeline hazard control: load-use stall, taken-branch flush, multi-cycle mul/div hold.
// Latency: stall/flush controls are combinational from ID/EX inputs; md_done is a registered pulse.
// Backpressure: front end stalls one cycle per load-use and for the whole mul/div busy phase.
// Feature macro: HAZARD_PERF_CNT_EN enables the stall_cycles counter (otherwise stall_cycles reads 0).
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md_op,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_hold,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  md_state_t state;
  md_state_t state_nxt;
  md_cnt_t   md_cnt;
  logic      load_use;
  logic      md_accept;
  logic      md_last;

  // A load in EX writing a register the ID instruction reads; r0 never creates a dependency.
  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  // Branch and load-use both take priority over starting a mul/div; a blocked op retries after the stall.
  assign md_accept = (state == IDLE) && id_md_op && !ex_branch_taken && !load_use;

  assign md_last = (state == MD_BUSY) && (md_cnt == md_cnt_t'(1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enter MD_BUSY on accept, return to IDLE on the last busy cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_accept) state_nxt = MD_BUSY;
      MD_BUSY: if (md_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mul/div down-counter and the registered completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= md_last;
      if (md_accept) begin
        md_cnt <= md_cnt_load(MD_CYCLES);
      end else if (state == MD_BUSY) begin
        md_cnt <= md_cnt - md_cnt_t'(1);
      end
    end
  end

  // Pipeline control outputs; while busy every front-end event is ignored.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_hold      = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    case (state)
      IDLE: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        ex_hold      = 1'b1;
        ex_mem_flush = 1'b1;
        md_busy      = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_perf_cnt u_perf_cnt (
    .clk    (clk),
    .clear  (rst),
    .enable (!pc_write),
    .count  (stall_cycles)
  );

endmodule
